// File: rtl/board_cursor_ctrl.sv
// Chess board cursor/selection sequencer: buttons -> cursor steps, piece selection, move handshake.
// Optional build macro CURSOR_WRAP_EN: cursor wraps at board edges instead of clamping.
module board_cursor_ctrl #(
  parameter int unsigned REPEAT_CYCLES = 25_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         BTN_UP,
  input  logic         BTN_DOWN,
  input  logic         BTN_LEFT,
  input  logic         BTN_RIGHT,
  input  logic         BTN_CENTER,
  input  logic [255:0] BOARD,
  output logic [5:0]   CURSOR_ADDR,
  output logic [5:0]   SELECT_ADDR,
  output logic         SELECT_EN,
  output logic         MOVE_VALID,
  output logic [5:0]   MOVE_FROM,
  output logic [5:0]   MOVE_TO,
  input  logic         MOVE_READY,
  output logic         TURN
);

  localparam int unsigned CNT_W = $clog2(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SELECTED, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [4:0]       btn_raw, btn_q, btn_prev_q, press, rel;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [5:0]       cursor_q, cursor_d, sel_addr_q, sel_addr_d;
  logic [5:0]       from_q, from_d, to_q, to_d;
  logic             sel_en_q, sel_en_d, valid_q, valid_d, turn_q, turn_d;
  logic             one_dir, rep_fire, own_piece;
  logic [3:0]       step_dir, sq;

  // Bit order {CENTER, RIGHT, LEFT, DOWN, UP}; lower index wins among directions.
  assign btn_raw   = {BTN_CENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};
  assign press     = btn_q & ~btn_prev_q;
  assign rel       = ~btn_q & btn_prev_q;
  assign one_dir   = $onehot(btn_q[3:0]);
  assign rep_fire  = one_dir && (press == 5'd0) && (rel == 5'd0) && (rep_cnt_q == CNT_LAST);
  assign sq        = BOARD[{cursor_q, 2'b00} +: 4];
  assign own_piece = (sq[2:0] != 3'd0) && (sq[3] == turn_q);

  function automatic logic [5:0] step_cursor(input logic [5:0] cur, input logic [3:0] dir);
    logic [2:0] row;
    logic [2:0] col;
    row = cur[5:3];
    col = cur[2:0];
`ifdef CURSOR_WRAP_EN
    if (dir[0])      row = row - 3'd1;
    else if (dir[1]) row = row + 3'd1;
    else if (dir[2]) col = col - 3'd1;
    else if (dir[3]) col = col + 3'd1;
`else
    if (dir[0] && row != 3'd0)      row = row - 3'd1;
    else if (dir[1] && row != 3'd7) row = row + 3'd1;
    else if (dir[2] && col != 3'd0) col = col - 3'd1;
    else if (dir[3] && col != 3'd7) col = col + 3'd1;
`endif
    return {row, col};
  endfunction

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    sel_addr_d = sel_addr_q;
    sel_en_d   = sel_en_q;
    from_d     = from_q;
    to_d       = to_q;
    valid_d    = valid_q;
    turn_d     = turn_q;
    rep_cnt_d  = rep_cnt_q + CNT_W'(1);
    step_dir   = 4'd0;

    if ((press != 5'd0) || (rel != 5'd0) || !one_dir || (rep_cnt_q == CNT_LAST)) begin
      rep_cnt_d = '0;
    end

    if (press[0])      step_dir = 4'b0001;
    else if (press[1]) step_dir = 4'b0010;
    else if (press[2]) step_dir = 4'b0100;
    else if (press[3]) step_dir = 4'b1000;
    else if (rep_fire) step_dir = btn_q[3:0];

    case (state_q)
      IDLE: begin
        if (press[4]) begin
          if (own_piece) begin
            sel_addr_d = cursor_q;
            sel_en_d   = 1'b1;
            state_d    = SELECTED;
          end
        end else begin
          cursor_d = step_cursor(cursor_q, step_dir);
        end
      end
      SELECTED: begin
        if (press[4]) begin
          if (cursor_q == sel_addr_q) begin
            sel_en_d = 1'b0;
            state_d  = IDLE;
          end else if (own_piece) begin
            sel_addr_d = cursor_q;
          end else begin
            from_d  = sel_addr_q;
            to_d    = cursor_q;
            valid_d = 1'b1;
            state_d = COMMIT;
          end
        end else begin
          cursor_d = step_cursor(cursor_q, step_dir);
        end
      end
      COMMIT: begin
        // Buttons are ignored here; only the handshake can leave this state.
        if (MOVE_READY) begin
          valid_d  = 1'b0;
          sel_en_d = 1'b0;
          turn_d   = ~turn_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cursor_q   <= 6'd52;
      sel_addr_q <= 6'd0;
      sel_en_q   <= 1'b0;
      from_q     <= 6'd0;
      to_q       <= 6'd0;
      valid_q    <= 1'b0;
      turn_q     <= 1'b0;
      rep_cnt_q  <= '0;
      // History primed with live levels so a button held through reset is not a press.
      btn_q      <= btn_raw;
      btn_prev_q <= btn_raw;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      sel_addr_q <= sel_addr_d;
      sel_en_q   <= sel_en_d;
      from_q     <= from_d;
      to_q       <= to_d;
      valid_q    <= valid_d;
      turn_q     <= turn_d;
      rep_cnt_q  <= rep_cnt_d;
      btn_q      <= btn_raw;
      btn_prev_q <= btn_q;
    end
  end

  assign CURSOR_ADDR = cursor_q;
  assign SELECT_ADDR = sel_addr_q;
  assign SELECT_EN   = sel_en_q;
  assign MOVE_VALID  = valid_q;
  assign MOVE_FROM   = from_q;
  assign MOVE_TO     = to_q;
  assign TURN        = turn_q;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Bench for board_cursor_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_board_cursor_ctrl;
  localparam int RC = 4;

  logic         clk;
  logic         rst;
  logic [4:0]   btn;      // {CENTER, RIGHT, LEFT, DOWN, UP}
  logic [255:0] board;
  logic         ready;
  logic [5:0]   cursor_addr, select_addr, move_from, move_to;
  logic         select_en, move_valid, turn;

  board_cursor_ctrl #(.REPEAT_CYCLES(RC)) dut (
    .clk(clk), .rst(rst),
    .BTN_UP(btn[0]), .BTN_DOWN(btn[1]), .BTN_LEFT(btn[2]), .BTN_RIGHT(btn[3]), .BTN_CENTER(btn[4]),
    .BOARD(board),
    .CURSOR_ADDR(cursor_addr), .SELECT_ADDR(select_addr), .SELECT_EN(select_en),
    .MOVE_VALID(move_valid), .MOVE_FROM(move_from), .MOVE_TO(move_to),
    .MOVE_READY(ready), .TURN(turn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model: state is just the visible outputs plus button sample history.
  int         m_cur, m_sel, m_from, m_to, elapsed;
  bit         m_sel_en, m_mv, m_turn;
  logic [4:0] h1, h2;

  function automatic int step(int cur, int dir);
    int r, c;
    r = cur / 8;
    c = cur % 8;
    case (dir)
      0:       r = r - 1;
      1:       r = r + 1;
      2:       c = c - 1;
      default: c = c + 1;
    endcase
`ifdef CURSOR_WRAP_EN
    r = (r + 8) % 8;
    c = (c + 8) % 8;
    return r * 8 + c;
`else
    if (r < 0 || r > 7 || c < 0 || c > 7) return cur;
    return r * 8 + c;
`endif
  endfunction

  always @(posedge clk) begin : model
    logic [4:0] pr;
    logic       evt, fire, own;
    logic [3:0] sq;
    int         dir;
    if (!rst) begin
      m_cur = 52; m_sel = 0; m_sel_en = 0; m_mv = 0; m_from = 0; m_to = 0; m_turn = 0;
      h1 = btn; h2 = btn; elapsed = 0;
    end else begin
      pr  = h1 & ~h2;
      evt = (h1 != h2);
      if (evt) elapsed = 0;
      else     elapsed = elapsed + 1;
      fire = !evt && ($countones(h1[3:0]) == 1) && (elapsed % RC == 0);
      sq   = board[m_cur*4 +: 4];
      own  = (sq[2:0] != 3'd0) && (sq[3] == m_turn);
      if (m_mv) begin
        if (ready) begin
          m_mv = 0; m_sel_en = 0; m_turn = !m_turn;
        end
      end else if (pr[4]) begin
        if (!m_sel_en) begin
          if (own) begin m_sel = m_cur; m_sel_en = 1; end
        end else if (m_cur == m_sel) begin
          m_sel_en = 0;
        end else if (own) begin
          m_sel = m_cur;
        end else begin
          m_from = m_sel; m_to = m_cur; m_mv = 1;
        end
      end else begin
        dir = -1;
        if (pr[0])      dir = 0;
        else if (pr[1]) dir = 1;
        else if (pr[2]) dir = 2;
        else if (pr[3]) dir = 3;
        else if (fire) begin
          for (int i = 0; i < 4; i++) if (h1[i]) dir = i;
        end
        if (dir >= 0) m_cur = step(m_cur, dir);
      end
      h2 = h1;
      h1 = btn;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL cyc=%0d %s got=%0d exp=%0d", cyc, nm, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    chk("cursor", cursor_addr, m_cur);
    chk("sel_en", select_en, m_sel_en);
    chk("sel_addr", select_addr, m_sel);
    chk("move_valid", move_valid, m_mv);
    chk("move_from", move_from, m_from);
    chk("move_to", move_to, m_to);
    chk("turn", turn, m_turn);
  endtask

  task automatic pulse(input int b);
    btn[b] = 1'b1;
    cycle();
    btn[b] = 1'b0;
    cycle();
    $display("cyc=%0d pulse btn%0d -> cursor=%0d sel_en=%0d sel=%0d mv=%0d turn=%0d",
             cyc, b, cursor_addr, select_en, select_addr, move_valid, turn);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  function automatic logic [255:0] init_board();
    logic [255:0] b;
    int code;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      code = (c == 0 || c == 7) ? 4 : (c == 1 || c == 6) ? 2 : (c == 2 || c == 5) ? 3 : (c == 3) ? 5 : 6;
      b[c*4 +: 4]      = 4'(8 + code);
      b[(8+c)*4 +: 4]  = 4'h9;
      b[(48+c)*4 +: 4] = 4'h1;
      b[(56+c)*4 +: 4] = 4'(code);
    end
    return b;
  endfunction

  task automatic accept(input int from, input int to);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    board[to*4 +: 4]   = board[from*4 +: 4];
    board[from*4 +: 4] = 4'h0;
    $display("cyc=%0d accept %0d->%0d mv=%0d turn=%0d", cyc, from, to, move_valid, turn);
  endtask

  initial begin
    int right_exp[4];
    right_exp[0] = 53; right_exp[1] = 54; right_exp[2] = 55;
`ifdef CURSOR_WRAP_EN
    right_exp[3] = 48;
`else
    right_exp[3] = 55;
`endif
    rst = 1'b0; btn = '0; ready = 1'b0; board = init_board();
    cycle();
    cycle();
    chk("lit_rst_cursor", cursor_addr, 52);
    chk("lit_rst_sel_en", select_en, 0);
    chk("lit_rst_mv", move_valid, 0);
    chk("lit_rst_turn", turn, 0);

    // UP held through reset release is not a press
    btn[0] = 1'b1; cycle(); rst = 1'b1; cycle(); cycle();
    chk("lit_held_up", cursor_addr, 52);
    btn[0] = 1'b0; cycle(); cycle();
    chk("lit_held_up_rel", cursor_addr, 52);

    for (int i = 0; i < 4; i++) begin
      pulse(3);
      chk("lit_right", cursor_addr, right_exp[i]);
    end

    // Select pawn, move 52 -> 36, stall handshake, then accept
    do_reset();
    pulse(4);
    chk("lit_sel_en", select_en, 1);
    chk("lit_sel_addr", select_addr, 52);
    pulse(0); pulse(0);
    chk("lit_cursor36", cursor_addr, 36);
    pulse(4);
    chk("lit_mv", move_valid, 1);
    chk("lit_from", move_from, 52);
    chk("lit_to", move_to, 36);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("lit_stall_mv", move_valid, 1);
      chk("lit_stall_from", move_from, 52);
      chk("lit_stall_to", move_to, 36);
    end
    accept(52, 36);
    chk("lit_acc_mv", move_valid, 0);
    chk("lit_acc_turn", turn, 1);
    chk("lit_acc_sel_en", select_en, 0);

    // CENTER on empty square, then black piece, with white to move
    do_reset();
    pulse(4);
    chk("lit_empty_sel", select_en, 0);
    for (int i = 0; i < 5; i++) pulse(0);
    chk("lit_cursor12", cursor_addr, 12);
    pulse(4);
    chk("lit_black_sel", select_en, 0);
    for (int i = 0; i < 3; i++) pulse(1);
    pulse(4);
    chk("lit_own_sel", select_en, 1);
    pulse(4);
    chk("lit_desel", select_en, 0);

    // Auto-repeat from square 0
    for (int i = 0; i < 4; i++) pulse(0);
    for (int i = 0; i < 4; i++) pulse(2);
    chk("lit_cursor0", cursor_addr, 0);
    btn[1] = 1'b1;
    cycle();
    for (int i = 0; i < 15; i++) begin
      cycle();
      chk("lit_repeat", cursor_addr, 8 * (1 + ((i > 12 ? 12 : i) / 4)));
      if (i == 11) btn[1] = 1'b0;
    end

    // UP and CENTER together: selection wins, cursor unchanged
    board = init_board();
    do_reset();
    btn[0] = 1'b1; btn[4] = 1'b1; cycle(); btn = '0; cycle();
    chk("lit_both_sel", select_en, 1);
    chk("lit_both_addr", select_addr, 52);
    chk("lit_both_cursor", cursor_addr, 52);
    pulse(0); pulse(4);
    chk("lit_mv2", move_valid, 1);
    accept(52, 44);
    for (int i = 0; i < 4; i++) pulse(0);
    pulse(4);
    chk("lit_black_sel2", select_en, 1);
    pulse(1); pulse(4);
    chk("lit_mv3", move_valid, 1);
    chk("lit_mv3_turn", turn, 1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("lit_rstc_mv", move_valid, 0);
    chk("lit_rstc_turn", turn, 0);

    // Random phase
    board = init_board();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 4)] ^= 1'b1;
      ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) board[$urandom_range(0, 63)*4 +: 4] = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) != 0);
      cycle();
      if (move_valid && ready)
        $display("cyc=%0d handshake from=%0d to=%0d", cyc, move_from, move_to);
    end
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
